// File: rtl/wb_pkg.sv
// Shared types and default widths for the queued Wishbone master engine.
package wb_pkg;

  localparam int unsigned WB_ADDR_WIDTH = 2;
  localparam int unsigned WB_DATA_WIDTH = 8;
  localparam int unsigned WB_SEL_WIDTH  = WB_DATA_WIDTH / 8;
  localparam int unsigned WB_FIFO_DEPTH = 4;
  localparam int unsigned WB_TIMEOUT    = 255;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } wb_op_t;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_ERR     = 2'd1,
    RSP_TIMEOUT = 2'd2
  } wb_rsp_status_t;

  typedef struct packed {
    wb_op_t                   we;
    logic [WB_ADDR_WIDTH-1:0] adr;
    logic [WB_DATA_WIDTH-1:0] dat;
    logic [WB_SEL_WIDTH-1:0]  sel;
  } wb_cmd_t;

  // Timeout counter width; a disabled timeout still keeps a 1-bit counter.
  function automatic int unsigned wb_cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous command FIFO; power-of-two depth so pointers wrap naturally.
module wb_cmd_fifo
  import wb_pkg::*;
#(
  parameter type         T     = wb_cmd_t,
  parameter int unsigned DEPTH = WB_FIFO_DEPTH
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     wr_data_i,
  input  logic pop_i,
  output T     rd_data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // Flags are registered from the next count so they never glitch.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_o  <= 1'b0;
      empty_o <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count_nxt;
      full_o  <= (count_nxt == CNT_W'(DEPTH));
      empty_o <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wr_data_i;
  end

  assign rd_data_o = mem[rd_ptr];

endmodule

// File: rtl/wb_master_engine.sv
// Queued Wishbone classic master: FIFO-buffered commands issued as single
// bus cycles with timeout, results returned through a one-entry response slot.
module wb_master_engine
  import wb_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter  int unsigned DATA_WIDTH = WB_DATA_WIDTH,
  localparam int unsigned SEL_WIDTH  = DATA_WIDTH / 8,
  parameter  int unsigned FIFO_DEPTH = WB_FIFO_DEPTH,
  parameter  int unsigned TIMEOUT    = WB_TIMEOUT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_adr_i,
  input  logic [DATA_WIDTH-1:0] req_dat_i,
  input  logic [SEL_WIDTH-1:0]  req_sel_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_we_o,
  output logic [DATA_WIDTH-1:0] rsp_dat_o,
  output logic [1:0]            rsp_status_o,
  output logic                  busy_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic [SEL_WIDTH-1:0]  sel_o,
  input  logic                  ack_i,
  input  logic                  err_i,
  input  logic [DATA_WIDTH-1:0] dat_i
);

  localparam int unsigned     TO_W    = wb_cnt_width(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef struct packed {
    wb_op_t                we;
    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] dat;
    logic [SEL_WIDTH-1:0]  sel;
  } cmd_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t          state;
  cmd_t            req_cmd;
  cmd_t            head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            slot_free;
  logic            pop;
  logic            timeout_hit;
  logic [TO_W-1:0] to_cnt;

  assign req_cmd.we  = wb_op_t'(req_we_i);
  assign req_cmd.adr = req_adr_i;
  assign req_cmd.dat = req_dat_i;
  assign req_cmd.sel = req_sel_i;

  wb_cmd_fifo #(
    .T     (cmd_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (req_valid_i),
    .wr_data_i (req_cmd),
    .pop_i     (pop),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Ready looks only at full, so a full FIFO refuses even on a popping edge.
  assign req_ready_o = !fifo_full;
  assign slot_free   = !rsp_valid_o || rsp_ready_i;
  assign pop         = (state == IDLE) && !fifo_empty && slot_free;
  assign timeout_hit = (TIMEOUT != 0) && (to_cnt == TO_LAST);
  assign busy_o      = !fifo_empty || cyc_o || rsp_valid_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      cyc_o        <= 1'b0;
      stb_o        <= 1'b0;
      we_o         <= 1'b0;
      adr_o        <= '0;
      dat_o        <= '0;
      sel_o        <= '0;
      to_cnt       <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_we_o     <= 1'b0;
      rsp_dat_o    <= '0;
      rsp_status_o <= RSP_OK;
    end else begin
      if (rsp_valid_o && rsp_ready_i) rsp_valid_o <= 1'b0;

      case (state)
        IDLE: begin
          if (pop) begin
            state  <= ISSUE;
            cyc_o  <= 1'b1;
            stb_o  <= 1'b1;
            we_o   <= head.we;
            adr_o  <= head.adr;
            dat_o  <= head.dat;
            sel_o  <= head.sel;
            to_cnt <= '0;
          end
        end
        ISSUE: begin
          // err outranks ack, and either outranks the timeout on the same edge.
          if (err_i || ack_i || timeout_hit) begin
            state       <= IDLE;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
            adr_o       <= '0;
            dat_o       <= '0;
            sel_o       <= '0;
            rsp_valid_o <= 1'b1;
            rsp_we_o    <= we_o;
            if (err_i) begin
              rsp_status_o <= RSP_ERR;
              rsp_dat_o    <= '0;
            end else if (ack_i) begin
              rsp_status_o <= RSP_OK;
              rsp_dat_o    <= we_o ? '0 : dat_i;
            end else begin
              rsp_status_o <= RSP_TIMEOUT;
              rsp_dat_o    <= '0;
            end
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_engine.sv
// Directed bench for wb_master_engine with a behavioural Wishbone slave.
module tb_wb_master_engine;

  localparam int unsigned AW = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned TO = 8;

  logic          clk_i;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_we_i;
  logic [AW-1:0] req_adr_i;
  logic [DW-1:0] req_dat_i;
  logic [SW-1:0] req_sel_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic          rsp_we_o;
  logic [DW-1:0] rsp_dat_o;
  logic [1:0]    rsp_status_o;
  logic          busy_o;
  logic          cyc_o;
  logic          stb_o;
  logic          we_o;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o;
  logic [SW-1:0] sel_o;
  logic          ack_i;
  logic          err_i;
  logic [DW-1:0] dat_i;

  int vectors = 0;
  int miscompares = 0;

  // Slave model: mode 0 ack, 1 err, 2 ack+err, 3 never respond.
  int         slave_mode = 0;
  int         slave_ws = 0;
  logic [31:0] smem [4];

  wb_master_engine #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (4),
    .TIMEOUT    (TO)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_adr_i    (req_adr_i),
    .req_dat_i    (req_dat_i),
    .req_sel_i    (req_sel_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_we_o     (rsp_we_o),
    .rsp_dat_o    (rsp_dat_o),
    .rsp_status_o (rsp_status_o),
    .busy_o       (busy_o),
    .cyc_o        (cyc_o),
    .stb_o        (stb_o),
    .we_o         (we_o),
    .adr_o        (adr_o),
    .dat_o        (dat_o),
    .sel_o        (sel_o),
    .ack_i        (ack_i),
    .err_i        (err_i),
    .dat_i        (dat_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : slave
    int ws_cnt;
    ws_cnt = 0;
    ack_i = 1'b0;
    err_i = 1'b0;
    dat_i = '0;
    forever begin
      @(negedge clk_i);
      ack_i = 1'b0;
      err_i = 1'b0;
      dat_i = 32'hDEAD_BEEF;
      if (cyc_o && stb_o && slave_mode != 3) begin
        if (ws_cnt >= slave_ws) begin
          ws_cnt = 0;
          case (slave_mode)
            0: begin
              ack_i = 1'b1;
              if (we_o) begin
                for (int b = 0; b < 4; b++)
                  if (sel_o[b]) smem[adr_o][8*b +: 8] = dat_o[8*b +: 8];
              end else begin
                dat_i = smem[adr_o];
              end
            end
            1: err_i = 1'b1;
            default: begin
              ack_i = 1'b1;
              err_i = 1'b1;
              dat_i = smem[adr_o];
            end
          endcase
        end else begin
          ws_cnt++;
        end
      end else begin
        ws_cnt = 0;
      end
    end
  end

  task automatic push_cmd(input logic we, input logic [AW-1:0] adr,
                          input logic [DW-1:0] dat, input logic [SW-1:0] sel);
    int guard = 0;
    @(negedge clk_i);
    req_we_i = we; req_adr_i = adr; req_dat_i = dat; req_sel_i = sel;
    req_valid_i = 1'b1;
    while (!req_ready_o && guard < 200) begin
      @(negedge clk_i);
      guard++;
    end
    if (guard >= 200) begin
      vectors++; miscompares++;
      $display("FAIL push_wait: req_ready_o stuck at %b, want 1", req_ready_o);
    end
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic get_rsp(output logic we, output logic [DW-1:0] dat, output logic [1:0] st);
    int guard = 0;
    @(negedge clk_i);
    while (!rsp_valid_o && guard < 200) begin
      @(negedge clk_i);
      guard++;
    end
    if (guard >= 200) begin
      vectors++; miscompares++;
      $display("FAIL rsp_wait: rsp_valid_o stuck at %b, want 1", rsp_valid_o);
    end
    we = rsp_we_o; dat = rsp_dat_o; st = rsp_status_o;
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk_i);
    vectors++; if (cyc_o !== 1'b0) begin miscompares++; $display("FAIL rst_cyc: got %b want 0", cyc_o); end
    vectors++; if (stb_o !== 1'b0) begin miscompares++; $display("FAIL rst_stb: got %b want 0", stb_o); end
    vectors++; if (we_o !== 1'b0) begin miscompares++; $display("FAIL rst_we: got %b want 0", we_o); end
    vectors++; if (adr_o !== 2'd0) begin miscompares++; $display("FAIL rst_adr: got %h want 0", adr_o); end
    vectors++; if (dat_o !== 32'd0) begin miscompares++; $display("FAIL rst_dat: got %h want 0", dat_o); end
    vectors++; if (sel_o !== 4'd0) begin miscompares++; $display("FAIL rst_sel: got %b want 0", sel_o); end
    vectors++; if (rsp_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid_o); end
    vectors++; if (rsp_we_o !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_we: got %b want 0", rsp_we_o); end
    vectors++; if (rsp_dat_o !== 32'd0) begin miscompares++; $display("FAIL rst_rsp_dat: got %h want 0", rsp_dat_o); end
    vectors++; if (rsp_status_o !== 2'd0) begin miscompares++; $display("FAIL rst_rsp_status: got %0d want 0", rsp_status_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    vectors++; if (req_ready_o !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b want 1", req_ready_o); end
  endtask

  task automatic test_latency;
    logic we; logic [DW-1:0] d; logic [1:0] st;
    slave_mode = 0; slave_ws = 0; smem[3] = 32'h0000_0077;
    push_cmd(1'b0, 2'd3, 32'd0, 4'hF);
    @(negedge clk_i);
    vectors++; if (cyc_o !== 1'b0) begin miscompares++; $display("FAIL lat_n0_cyc: got %b want 0", cyc_o); end
    @(negedge clk_i);
    vectors++; if (cyc_o !== 1'b1 || stb_o !== 1'b1) begin miscompares++; $display("FAIL lat_n1_cyc: got cyc %b stb %b want 1 1", cyc_o, stb_o); end
    vectors++; if (adr_o !== 2'd3 || we_o !== 1'b0) begin miscompares++; $display("FAIL lat_n1_adr: got adr %0d we %b want 3 0", adr_o, we_o); end
    @(negedge clk_i);
    vectors++; if (rsp_valid_o !== 1'b1 || cyc_o !== 1'b0) begin miscompares++; $display("FAIL lat_n2: got rsp_valid %b cyc %b want 1 0", rsp_valid_o, cyc_o); end
    get_rsp(we, d, st);
    vectors++; if (we !== 1'b0 || st !== 2'd0 || d !== 32'h77) begin miscompares++; $display("FAIL lat_rsp: got we %b st %0d dat %h want 0 0 77", we, st, d); end
  endtask

  task automatic test_write_read;
    logic we; logic [DW-1:0] d; logic [1:0] st;
    slave_mode = 0; slave_ws = 1; smem[1] = 32'd0;
    push_cmd(1'b1, 2'd1, 32'h0000_00A5, 4'b0001);
    push_cmd(1'b0, 2'd1, 32'd0, 4'b0001);
    get_rsp(we, d, st);
    vectors++; if (we !== 1'b1 || st !== 2'd0 || d !== 32'd0) begin miscompares++; $display("FAIL wr_rsp: got we %b st %0d dat %h want 1 0 0", we, st, d); end
    get_rsp(we, d, st);
    vectors++; if (we !== 1'b0 || st !== 2'd0 || d !== 32'h0000_00A5) begin miscompares++; $display("FAIL rd_rsp: got we %b st %0d dat %h want 0 0 a5", we, st, d); end
  endtask

  task automatic test_fifo_full;
    logic cw [6]; logic [AW-1:0] ca [6]; logic [DW-1:0] cd [6]; logic [DW-1:0] ed [6];
    slave_mode = 0; slave_ws = 0;
    smem[0] = 32'h10; smem[1] = 32'h21; smem[2] = 32'h32; smem[3] = 32'h43;
    for (int i = 0; i < 4; i++) begin
      cw[i] = 1'b0; ca[i] = AW'(i); cd[i] = '0;
    end
    ed[0] = 32'h10; ed[1] = 32'h21; ed[2] = 32'h32; ed[3] = 32'h43;
    cw[4] = 1'b1; ca[4] = 2'd2; cd[4] = 32'h55; ed[4] = 32'h0;
    cw[5] = 1'b0; ca[5] = 2'd2; cd[5] = 32'h0;  ed[5] = 32'h55;
    for (int i = 0; i < 5; i++) push_cmd(cw[i], ca[i], cd[i], 4'hF);
    @(negedge clk_i);
    vectors++; if (req_ready_o !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %b want 0", req_ready_o); end
    vectors++; if (rsp_valid_o !== 1'b1 || busy_o !== 1'b1) begin miscompares++; $display("FAIL full_slot: got rsp_valid %b busy %b want 1 1", rsp_valid_o, busy_o); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      vectors++; if (cyc_o !== 1'b0) begin miscompares++; $display("FAIL full_stall_cyc%0d: got %b want 0", k, cyc_o); end
    end
    fork
      push_cmd(cw[5], ca[5], cd[5], 4'hF);
      begin
        logic we; logic [DW-1:0] d; logic [1:0] st;
        for (int i = 0; i < 6; i++) begin
          get_rsp(we, d, st);
          vectors++;
          if (we !== cw[i] || st !== 2'd0 || d !== ed[i]) begin
            miscompares++;
            $display("FAIL full_rsp%0d: got we %b st %0d dat %h want %b 0 %h", i, we, st, d, cw[i], ed[i]);
          end
        end
      end
    join
  endtask

  task automatic test_timeout;
    logic we; logic [DW-1:0] d; logic [1:0] st;
    int guard = 0;
    int high = 0;
    slave_mode = 3;
    push_cmd(1'b0, 2'd3, 32'd0, 4'hF);
    @(negedge clk_i);
    while (!cyc_o && guard < 20) begin @(negedge clk_i); guard++; end
    while (cyc_o && high < 50) begin high++; @(negedge clk_i); end
    vectors++; if (high != 8) begin miscompares++; $display("FAIL to_cyc_len: got %0d cycles want 8", high); end
    get_rsp(we, d, st);
    vectors++; if (we !== 1'b0 || st !== 2'd2 || d !== 32'd0) begin miscompares++; $display("FAIL to_rsp: got we %b st %0d dat %h want 0 2 0", we, st, d); end
    slave_mode = 0; slave_ws = 0; smem[0] = 32'h99;
    push_cmd(1'b0, 2'd0, 32'd0, 4'hF);
    get_rsp(we, d, st);
    vectors++; if (we !== 1'b0 || st !== 2'd0 || d !== 32'h99) begin miscompares++; $display("FAIL to_next: got we %b st %0d dat %h want 0 0 99", we, st, d); end
  endtask

  task automatic test_err_priority;
    logic we; logic [DW-1:0] d; logic [1:0] st;
    slave_mode = 2; slave_ws = 0; smem[1] = 32'hA5;
    push_cmd(1'b0, 2'd1, 32'd0, 4'hF);
    get_rsp(we, d, st);
    vectors++; if (we !== 1'b0 || st !== 2'd1 || d !== 32'd0) begin miscompares++; $display("FAIL err_both: got we %b st %0d dat %h want 0 1 0", we, st, d); end
    slave_mode = 1;
    push_cmd(1'b1, 2'd2, 32'h12, 4'hF);
    get_rsp(we, d, st);
    vectors++; if (we !== 1'b1 || st !== 2'd1 || d !== 32'd0) begin miscompares++; $display("FAIL err_write: got we %b st %0d dat %h want 1 1 0", we, st, d); end
  endtask

  task automatic test_width_sel;
    logic we; logic [DW-1:0] d; logic [1:0] st;
    int guard = 0;
    int high = 0;
    slave_mode = 0; slave_ws = 2; smem[2] = 32'h1122_3344;
    push_cmd(1'b1, 2'd2, 32'hCAFE_BABE, 4'b0110);
    @(negedge clk_i);
    while (!cyc_o && guard < 20) begin @(negedge clk_i); guard++; end
    while (cyc_o && high < 20) begin
      high++;
      vectors++;
      if (sel_o !== 4'b0110 || adr_o !== 2'd2 || dat_o !== 32'hCAFE_BABE || we_o !== 1'b1) begin
        miscompares++;
        $display("FAIL ws_hold%0d: got sel %b adr %0d dat %h we %b want 0110 2 cafebabe 1", high, sel_o, adr_o, dat_o, we_o);
      end
      @(negedge clk_i);
    end
    vectors++; if (high != 3) begin miscompares++; $display("FAIL ws_len: got %0d cycles want 3", high); end
    vectors++; if (sel_o !== 4'd0 || adr_o !== 2'd0 || dat_o !== 32'd0 || we_o !== 1'b0 || stb_o !== 1'b0) begin
      miscompares++; $display("FAIL ws_idle_bus: got sel %b adr %0d dat %h we %b stb %b want all 0", sel_o, adr_o, dat_o, we_o, stb_o);
    end
    get_rsp(we, d, st);
    vectors++; if (we !== 1'b1 || st !== 2'd0 || d !== 32'd0) begin miscompares++; $display("FAIL ws_wr_rsp: got we %b st %0d dat %h want 1 0 0", we, st, d); end
    push_cmd(1'b0, 2'd2, 32'd0, 4'hF);
    get_rsp(we, d, st);
    vectors++; if (we !== 1'b0 || st !== 2'd0 || d !== 32'h11FE_BA44) begin miscompares++; $display("FAIL ws_rd_rsp: got we %b st %0d dat %h want 0 0 11feba44", we, st, d); end
  endtask

  task automatic test_reset_mid;
    logic we; logic [DW-1:0] d; logic [1:0] st;
    slave_mode = 3; smem[3] = 32'h66;
    for (int i = 0; i < 4; i++) push_cmd(1'b0, AW'(i), 32'd0, 4'hF);
    @(negedge clk_i);
    vectors++; if (cyc_o !== 1'b1) begin miscompares++; $display("FAIL rm_pre_cyc: got %b want 1", cyc_o); end
    rst_i = 1'b0;
    #1;
    vectors++; if (cyc_o !== 1'b0 || stb_o !== 1'b0) begin miscompares++; $display("FAIL rm_async: got cyc %b stb %b want 0 0", cyc_o, stb_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    vectors++; if (busy_o !== 1'b0 || req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
      miscompares++; $display("FAIL rm_release: got busy %b ready %b rsp_valid %b want 0 1 0", busy_o, req_ready_o, rsp_valid_o);
    end
    slave_mode = 0; slave_ws = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      vectors++; if (cyc_o !== 1'b0 || rsp_valid_o !== 1'b0) begin miscompares++; $display("FAIL rm_stale%0d: got cyc %b rsp_valid %b want 0 0", k, cyc_o, rsp_valid_o); end
    end
    push_cmd(1'b0, 2'd3, 32'd0, 4'hF);
    get_rsp(we, d, st);
    vectors++; if (we !== 1'b0 || st !== 2'd0 || d !== 32'h66) begin miscompares++; $display("FAIL rm_after: got we %b st %0d dat %h want 0 0 66", we, st, d); end
  endtask

  initial begin
    rst_i = 1'b0;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_adr_i = '0; req_dat_i = '0; req_sel_i = '0;
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) smem[i] = 32'd0;
    repeat (3) @(posedge clk_i);
    test_reset;
    @(negedge clk_i);
    rst_i = 1'b1;
    test_latency;
    test_write_read;
    test_fifo_full;
    test_timeout;
    test_err_priority;
    test_width_sel;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_master_engine.md
# wb_master_engine

Synthesizable, parametrised Wishbone classic master that replaces procedural bus driving with a queued command engine. Commands enter through a valid/ready request channel, are buffered in a small FIFO and issued as single Wishbone cycles with byte selects. Each cycle is bounded by a timeout and reported back through a valid/ready response channel carrying read data and a status code. It sits between any sequencer/CPU-side logic and a Wishbone slave (e.g. the I2C controller register block).

## Interface
- ADDR_WIDTH, 2, Wishbone address width
- DATA_WIDTH, 8, Wishbone data width; multiple of 8
- SEL_WIDTH, DATA_WIDTH/8, byte-select width; derived, not overridden
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2
- TIMEOUT, 255, max cycles waiting for ack/err; 0 disables timeout

Ports:
- clk_i  in  1  clock; all logic on posedge
- rst_i  in  1  asynchronous, active-low reset
- req_valid_i  in  1  command valid
- req_ready_o  out  1  command accepted when valid&ready; = !fifo_full
- req_we_i  in  1  1 write, 0 read
- req_adr_i  in  ADDR_WIDTH  command address
- req_dat_i  in  DATA_WIDTH  write data (ignored for reads)
- req_sel_i  in  SEL_WIDTH  byte selects
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_we_o  out  1  op of completed command
- rsp_dat_o  out  DATA_WIDTH  read data; 0 for writes, err, timeout
- rsp_status_o  out  2  0 OK, 1 ERR, 2 TIMEOUT
- busy_o  out  1  FIFO non-empty or bus cycle or response pending
- cyc_o, stb_o, we_o  out  1 each  Wishbone controls
- adr_o  out  ADDR_WIDTH; dat_o  out  DATA_WIDTH; sel_o  out  SEL_WIDTH
- ack_i, err_i  in  1 each; dat_i  in  DATA_WIDTH

## Operation
- FSM states: IDLE, ISSUE.
- IDLE → ISSUE when FIFO non-empty and response slot free (!rsp_valid_o or rsp_ready_i this cycle); pop head, register we/adr/dat/sel, assert cyc_o/stb_o.
- ISSUE: hold all bus outputs stable; count cycles.
  - err_i high → status ERR, data 0.
  - else ack_i high → status OK, data = dat_i for reads, 0 for writes.
  - else count reaches TIMEOUT (TIMEOUT≠0) → abort, status TIMEOUT, data 0.
  - on any exit: drop cyc/stb, load response slot, → IDLE.
- err beats ack on the same edge; ack/err beat timeout on the same edge.
- Outside ISSUE, we_o/adr_o/dat_o/sel_o are driven 0 (never X).
- Response slot is single-entry: holds until rsp_ready_i; a new cycle never overwrites an unconsumed response.
- FIFO push when req_valid_i & req_ready_o. Ready depends on full only: a full FIFO refuses a push even when popping on the same edge.
- Timeout counter width $clog2(TIMEOUT+1); it clears on entry to ISSUE.

## Timing
- Reset values: cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, rsp_valid_o, rsp_* and busy_o = 0; req_ready_o = 1. FIFO is empty, FSM is in IDLE.
- Reset mid-cycle: cyc_o/stb_o drop asynchronously, FIFO is flushed, the pending response is discarded.
- Command pushed at edge N → popped at N+1 → cyc_o high after N+1.
- Earliest ack sampled at N+2 → rsp_valid_o high and cyc_o low after N+2. Request-to-response latency is 2 cycles minimum.
- Back-to-back commands: cyc_o low for at least one full cycle between cycles.
- Timeout: with no ack/err, abort fires on the TIMEOUT-th edge after cyc_o rises.
- Responses are returned in command order.

## Structure
- wb_pkg holds:
  - wb_op_t
  - wb_rsp_status_t enum (RSP_OK, RSP_ERR, RSP_TIMEOUT)
  - packed wb_cmd_t struct {we, adr, dat, sel}
  - default width constants
- Sub-module wb_cmd_fifo: synchronous FIFO of wb_cmd_t, parametrised depth, with full/empty flags and pointer wrap on power-of-two depth.
- Engine FSM, timeout counter and response slot live in wb_master_engine.

## Test plan
- Write then read: push write adr=1 dat=0xA5 sel=1, then read adr=1; slave acks after 1 wait state → responses in order: {we=1, OK, dat=0}, then {we=0, OK, dat=0xA5}.
- FIFO full: hold rsp_ready_i=0, push 6 commands → req_ready_o low after the 4th queued entry (one further command has left the FIFO into the engine); no bus cycle starts while the response slot is full; drain → all 6 complete in order.
- Timeout: TIMEOUT=8, slave never acks → cyc_o high exactly 8 cycles; response {TIMEOUT, dat=0}; the next command issues normally.
- Error priority: ack_i and err_i both high on one edge for a read → status ERR, rsp_dat_o=0.
- Reset mid-cycle: rst_i low while cyc_o high with 3 commands queued → cyc_o drops immediately; after release, busy_o=0, req_ready_o=1, no stale response.
- Width sweep: DATA_WIDTH=32, sel=4'b0110 write → sel_o=4'b0110 held for the whole cycle; bus outputs are 0 between cycles.
